req_latch8: RTL and testbench

REQ_LATCH8 -- requirements
Module: req_latch8

---
 rtl/req_latch8_if.sv | 21 ++
 rtl/req_latch8.sv | 92 +++++++++
 tb/tb_req_latch8.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/req_latch8_if.sv
// Request-latch bus: raw request/mask/acknowledge inputs and the pending/irq/overrun outputs.
// The master drives requests and acknowledges, the slave is the latch block.
interface req_latch8_if;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic [2:0] ack_idx;
    logic [7:0] pend;
    logic       irq;
    logic [7:0] ovf;

    modport master (
        output req, mask, ack, ack_idx,
        input  pend, irq, ovf
    );

    modport slave (
        input  req, mask, ack, ack_idx,
        output pend, irq, ovf
    );
endinterface

// File: rtl/req_latch8.sv
// 8-source request latch with masked pending vector, irq handshake FSM and sticky overrun flags.
// Define REQ_LATCH8_LEVEL_EN for level capture (ovf tied to zero); the default is rising-edge capture.
module req_latch8 (
    input  logic         clk,
    input  logic         rst,
    req_latch8_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] pend_reg;
    logic [7:0] req_d;
    logic [7:0] cap;
    logic [7:0] clr;
    logic [7:0] masked;
    logic       ack_take;

`ifdef REQ_LATCH8_LEVEL_EN
    assign cap = bus.req;
`else
    assign cap = bus.req & ~req_d;
`endif

    assign masked = pend_reg & bus.mask;

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        ack_take   = 1'b0;
        case (state)
            IDLE: begin
                if (masked != 8'h00) state_next = REQ;
            end
            REQ: begin
                if (bus.ack) begin
                    ack_take   = 1'b1;
                    state_next = SVC;
                end else if (masked == 8'h00) begin
                    state_next = IDLE;
                end
            end
            SVC: begin
                state_next = (masked != 8'h00) ? REQ : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Acknowledges only take effect in REQ; IDLE/SVC ignore them entirely.
    assign clr = ack_take ? (8'h01 << bus.ack_idx) : 8'h00;

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pend_reg <= 8'h00;
            req_d    <= 8'h00;
        end else begin
            state    <= state_next;
            req_d    <= bus.req;
            // Set is applied after clear so a same-edge capture wins over the acknowledge.
            pend_reg <= (pend_reg & ~clr) | cap;
        end
    end

`ifdef REQ_LATCH8_LEVEL_EN
    assign bus.ovf = 8'h00;
`else
    logic [7:0] ovf_reg;

    // A capture on an already-pending bit is an overrun; the acknowledge of that bit clears it, even same-edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 8'h00;
        end else begin
            ovf_reg <= (ovf_reg | (cap & pend_reg)) & ~clr;
        end
    end

    assign bus.ovf = ovf_reg;
`endif

    assign bus.pend = masked;
    assign bus.irq  = (state == REQ);

endmodule

// File: tb/tb_req_latch8.sv
// Self-checking bench for req_latch8: per-cycle compare against a behavioural model plus directed literal checks.
// Build with REQ_LATCH8_LEVEL_EN defined to exercise the level-capture variant.
module tb_req_latch8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    bit   armed;

    req_latch8_if bus ();

    req_latch8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: pending/overrun as bit sets, irq as "visible work and not just acknowledged".
    logic [7:0] m_pend;
    logic [7:0] m_ovf;
    logic [7:0] m_prev;
    logic       m_irq;

    always @(posedge clk) begin : model_upd
        logic [7:0] cap_m;
        logic [7:0] clr_m;
        logic [7:0] np;
        logic [7:0] no;
        bit         took_ack;
        if (rst) begin
            m_pend <= 8'h00;
            m_ovf  <= 8'h00;
            m_prev <= 8'h00;
            m_irq  <= 1'b0;
        end else begin
            took_ack = (m_irq === 1'b1) && bus.ack;
            clr_m = 8'h00;
            if (took_ack) clr_m[bus.ack_idx] = 1'b1;
            for (int i = 0; i < 8; i++) begin
`ifdef REQ_LATCH8_LEVEL_EN
                cap_m[i] = bus.req[i];
                no[i]    = 1'b0;
`else
                cap_m[i] = bus.req[i] && !m_prev[i];
                no[i]    = clr_m[i] ? 1'b0 : (m_ovf[i] || (cap_m[i] && m_pend[i]));
`endif
                np[i] = cap_m[i] ? 1'b1 : (clr_m[i] ? 1'b0 : m_pend[i]);
            end
            m_pend <= np;
            m_ovf  <= no;
            m_prev <= bus.req;
            m_irq  <= took_ack ? 1'b0 : ((m_pend & bus.mask) != 8'h00);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Compare process: one cycle-by-cycle check of all outputs, 1 time unit after each edge.
    always @(posedge clk) begin
        #1;
        if (armed) begin
            check("model_pend", bus.pend, m_pend & bus.mask);
            check("model_irq", {7'd0, bus.irq}, {7'd0, m_irq});
            check("model_ovf", bus.ovf, m_ovf);
        end
    end

    task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] m,
                        input logic a, input logic [2:0] idx);
        @(negedge clk);
        rst         = r;
        bus.req     = rq;
        bus.mask    = m;
        bus.ack     = a;
        bus.ack_idx = idx;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] p, input logic i, input logic [7:0] o);
        check({tag, "_pend"}, bus.pend, p);
        check({tag, "_irq"}, {7'd0, bus.irq}, {7'd0, i});
        check({tag, "_ovf"}, bus.ovf, o);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        armed       = 1'b0;
        rst         = 1'b1;
        bus.req     = 8'h00;
        bus.mask    = 8'hFF;
        bus.ack     = 1'b0;
        bus.ack_idx = 3'd0;

        step(1'b1, 8'h00, 8'hFF, 1'b0, 3'd0);
        armed = 1'b1;
        step(1'b1, 8'h00, 8'hFF, 1'b0, 3'd0);
        expect_out("reset", 8'h00, 1'b0, 8'h00);

`ifdef REQ_LATCH8_LEVEL_EN
        step(1'b0, 8'h01, 8'hFF, 1'b0, 3'd0); expect_out("lvl_cap", 8'h01, 1'b0, 8'h00);
        step(1'b0, 8'h01, 8'hFF, 1'b0, 3'd0); expect_out("lvl_irq", 8'h01, 1'b1, 8'h00);
        step(1'b0, 8'h01, 8'hFF, 1'b1, 3'd0); expect_out("lvl_hold_ack", 8'h01, 1'b0, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0); expect_out("lvl_reassert", 8'h01, 1'b1, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b1, 3'd0); expect_out("lvl_release_ack", 8'h00, 1'b0, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0); expect_out("lvl_idle", 8'h00, 1'b0, 8'h00);
        step(1'b1, 8'h04, 8'hFF, 1'b0, 3'd0); expect_out("lvl_rst", 8'h00, 1'b0, 8'h00);
        step(1'b0, 8'h04, 8'h00, 1'b0, 3'd0); expect_out("lvl_masked", 8'h00, 1'b0, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0); expect_out("lvl_unmask", 8'h04, 1'b1, 8'h00);
`else
        // Basic capture and latency, then two acknowledges with one-cycle SVC gaps.
        step(1'b0, 8'h24, 8'hFF, 1'b0, 3'd0); expect_out("cap24", 8'h24, 1'b0, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0); expect_out("irq24", 8'h24, 1'b1, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b1, 3'd5); expect_out("ack5", 8'h04, 1'b0, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0); expect_out("svc5_done", 8'h04, 1'b1, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b1, 3'd2); expect_out("ack2", 8'h00, 1'b0, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0); expect_out("idle0", 8'h00, 1'b0, 8'h00);

        // Overrun on a repeated edge, cleared by its acknowledge.
        step(1'b0, 8'h08, 8'hFF, 1'b0, 3'd0); expect_out("cap3a", 8'h08, 1'b0, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0); expect_out("irq3", 8'h08, 1'b1, 8'h00);
        step(1'b0, 8'h08, 8'hFF, 1'b0, 3'd0); expect_out("ovf3", 8'h08, 1'b1, 8'h08);
        step(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0); expect_out("ovf3_hold", 8'h08, 1'b1, 8'h08);
        step(1'b0, 8'h00, 8'hFF, 1'b1, 3'd3); expect_out("ack3", 8'h00, 1'b0, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0); expect_out("idle1", 8'h00, 1'b0, 8'h00);

        // Masked capture stays stored; unmask raises irq; mask drop in REQ returns to IDLE.
        step(1'b0, 8'h80, 8'h0F, 1'b0, 3'd0); expect_out("cap7_masked", 8'h00, 1'b0, 8'h00);
        step(1'b0, 8'h00, 8'h0F, 1'b0, 3'd0); expect_out("masked_idle", 8'h00, 1'b0, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0); expect_out("unmask7", 8'h80, 1'b1, 8'h00);
        step(1'b0, 8'h00, 8'h0F, 1'b0, 3'd0); expect_out("remask_idle", 8'h00, 1'b0, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0); expect_out("unmask7b", 8'h80, 1'b1, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b1, 3'd7); expect_out("ack7", 8'h00, 1'b0, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0); expect_out("idle2", 8'h00, 1'b0, 8'h00);

        // Ack ignored in IDLE and SVC; set-wins collision; ack of a non-pending index.
        step(1'b0, 8'h02, 8'hFF, 1'b1, 3'd1); expect_out("ack_in_idle", 8'h02, 1'b0, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0); expect_out("irq1", 8'h02, 1'b1, 8'h00);
        step(1'b0, 8'h02, 8'hFF, 1'b1, 3'd1); expect_out("set_wins", 8'h02, 1'b0, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b1, 3'd1); expect_out("ack_in_svc", 8'h02, 1'b1, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b1, 3'd6); expect_out("ack_empty6", 8'h02, 1'b0, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0); expect_out("reirq1", 8'h02, 1'b1, 8'h00);
        step(1'b0, 8'h02, 8'hFF, 1'b0, 3'd0); expect_out("ovf1", 8'h02, 1'b1, 8'h02);

        // Reset overrides ack mid-REQ; a line held through reset is captured on release.
        step(1'b1, 8'h00, 8'hFF, 1'b1, 3'd1); expect_out("rst_mid_req", 8'h00, 1'b0, 8'h00);
        step(1'b1, 8'h10, 8'hFF, 1'b0, 3'd0); expect_out("rst_held", 8'h00, 1'b0, 8'h00);
        step(1'b0, 8'h10, 8'hFF, 1'b0, 3'd0); expect_out("cap_after_rst", 8'h10, 1'b0, 8'h00);
        step(1'b0, 8'h10, 8'hFF, 1'b0, 3'd0); expect_out("held_no_ovf", 8'h10, 1'b1, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b1, 3'd4); expect_out("ack4", 8'h00, 1'b0, 8'h00);
        step(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0); expect_out("idle3", 8'h00, 1'b0, 8'h00);
`endif

        step(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
